uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- Memory-mapped UART transmit peripheral. It is the outbound counterpart of the receive path on the computer's uart_rx/uart_tx pins.
- The CPU writes bytes into a small FIFO. A framing FSM serialises them onto uart_tx as 8N1, LSB first.
- Sits beside the output port in the computer top level, driven by the CPU's I/O write decode.

Parameters:
- CLOCK_FREQ, 20_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- DATA_WIDTH, 8, byte width (from arch_defs_pkg).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data_i  input  DATA_WIDTH  byte to enqueue.
- tx_write_i  input  1  single-cycle write strobe from CPU I/O decode.
- tx_busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full_o  output  1  FIFO holds FIFO_DEPTH bytes.
- fifo_empty_o  output  1  FIFO holds zero bytes.
- overflow_o  output  1  sticky: a write was dropped.
- uart_tx  output  1  serial line; idle high.

Behaviour:
- Reset (async, immediate): uart_tx=1, FSM=IDLE, FIFO pointers and count cleared.
  - Output values during reset: fifo_empty_o=1, fifo_full_o=0, tx_busy_o=0, overflow_o=0.
  - Reset mid-frame abandons the frame; the line returns high with no stop bit.
- Bit timing:
  - CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division).
  - Baud counter runs 0..CLKS_PER_BIT-1; every bit, including start and stop, is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP (uart_state_t).
  - IDLE: uart_tx=1. If FIFO is non-empty, pop the head into the shift register, clear the counters, and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=shift[0]; shift right at the end of each bit. Go to STOP after bit_idx=DATA_WIDTH-1.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
    - If the FIFO is non-empty on the final stop-bit cycle, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Latency: with FSM idle and FIFO empty, a strobe at edge N is written at N, popped at N+1, and uart_tx falls at N+2.
- uart_tx is registered (glitch-free).
- FIFO write rules:
  - A write is accepted iff !full, or a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow_o sets. overflow_o clears only on reset.
  - Simultaneous write and pop when empty is impossible: a pop requires non-empty.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Flag timing: fifo_full_o and fifo_empty_o are derived from the registered count and update the cycle after the write or pop.
- tx_busy_o = (state != IDLE) || !fifo_empty_o.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; it drives the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11 bits.
- Undefined: the PARITY state and its logic are absent; frame is 8N1, 10 bits.

Decomposition:
- arch_defs_pkg: add uart_state_t enum (IDLE, START, DATA, STOP, PARITY) and a UART_BAUD_RATE constant. DATA_WIDTH is already present.
- One sub-module: sync_fifo (parameters DATA_WIDTH, DEPTH; ports push, pop, din, dout, full, empty). It is reused by the future receive path.

Test Plan (CLOCK_FREQ=100, BAUD_RATE=10, so CLKS_PER_BIT=10):
- Single byte: write 0xA5 while idle.
  - uart_tx falls exactly 2 cycles after the strobe.
  - Bits sampled at mid-bit read 0,1,0,1,0,0,1,0,1,1 (start, LSB..MSB, stop).
  - tx_busy_o drops 100 cycles after the start bit begins.
- Back-to-back: write 0x01, then 0xFF on the next cycle.
  - Second start bit begins immediately after the first stop bit (no idle cycles).
  - Total line-low/high pattern spans 200 cycles.
- Full/overflow: write 0x10..0x15 (6 bytes) on consecutive cycles, FIFO_DEPTH=4.
  - First pop frees one slot, so 5 bytes are transmitted in order 0x10..0x14.
  - 0x15 is dropped; overflow_o=1 and stays 1.
- Reset mid-frame: assert reset during data bit 3 of 0x3C.
  - uart_tx=1 within the same cycle (async); fifo_empty_o=1, overflow_o=0.
  - After release, writing 0x55 transmits a clean frame.
- Parity (UART_TX_PARITY_EN defined): write 0x07.
  - Parity bit=1, and the stop bit starts at cycle 100 from the start bit.
  - Repeating with 0x03 gives parity bit=0.
- Idle line: no writes for 500 cycles after reset → uart_tx constantly 1, tx_busy_o=0.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Architecture-wide definitions shared by the computer's datapath and I/O peripherals,
// including the UART transmit FSM states and the even-parity helper.
package arch_defs_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int UART_BAUD_RATE = 115200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;

  // Even parity: the bit that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head read, shared by the UART transmit
// and receive paths. A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO_CNT = {(PTR_W + 1){1'b0}};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W:0]        count_r;
  logic                  wr_en_s;
  logic                  rd_en_s;

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == ZERO_CNT);
  assign rd_en_s = pop && !empty;
  assign wr_en_s = push && (!full || rd_en_s);
  assign dout    = mem_r[rd_ptr_r];

  // Storage array: no reset needed, contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Memory-mapped UART transmitter: CPU writes land in a FIFO, a framing FSM sends 8N1
// LSB first. Defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_transmitter
  import arch_defs_pkg::*;
#(
  parameter int CLOCK_FREQ = 20_000_000,
  parameter int BAUD_RATE  = UART_BAUD_RATE,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_write_i,
  output logic                  tx_busy_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  overflow_o,
  output logic                  uart_tx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  uart_state_t           state_r;
  uart_state_t           state_s;
  logic [CNT_W-1:0]      baud_r;
  logic [CNT_W-1:0]      baud_s;
  logic [IDX_W-1:0]      bit_r;
  logic [IDX_W-1:0]      bit_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_s;
  logic                  tx_r;
  logic                  tx_s;
  logic                  overflow_r;
  logic                  pop_s;
  logic                  last_s;
  logic [DATA_WIDTH-1:0] fifo_dout_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
`ifdef UART_TX_PARITY_EN
  logic                  parity_r;
  logic                  parity_s;
`endif

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_write_i),
    .pop   (pop_s),
    .din   (tx_data_i),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign fifo_full_o  = fifo_full_s;
  assign fifo_empty_o = fifo_empty_s;
  assign overflow_o   = overflow_r;
  assign uart_tx      = tx_r;
  assign tx_busy_o    = (state_r != IDLE) || !fifo_empty_s;

  // Framing FSM next state; the line level is computed here and registered one cycle later.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    tx_s    = 1'b1;
    last_s  = (baud_r == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_s = fifo_dout_s;
          baud_s  = {CNT_W{1'b0}};
          bit_s   = {IDX_W{1'b0}};
          state_s = START;
`ifdef UART_TX_PARITY_EN
          parity_s = even_parity(fifo_dout_s);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (last_s) begin
          baud_s  = {CNT_W{1'b0}};
          bit_s   = {IDX_W{1'b0}};
          state_s = DATA;
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      DATA: begin
        tx_s = shift_r[0];
        if (last_s) begin
          baud_s  = {CNT_W{1'b0}};
          shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          if (bit_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + IDX_W'(1);
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_s = parity_r;
        if (last_s) begin
          baud_s  = {CNT_W{1'b0}};
          state_s = STOP;
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        tx_s = 1'b1;
        if (last_s) begin
          baud_s = {CNT_W{1'b0}};
          // A queued byte starts immediately so consecutive frames have no idle gap.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_s = fifo_dout_s;
            bit_s   = {IDX_W{1'b0}};
            state_s = START;
`ifdef UART_TX_PARITY_EN
            parity_s = even_parity(fifo_dout_s);
`endif
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        tx_s    = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and the registered line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      baud_r  <= {CNT_W{1'b0}};
      bit_r   <= {IDX_W{1'b0}};
      shift_r <= {DATA_WIDTH{1'b0}};
      tx_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
`ifdef UART_TX_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  // Sticky flag for a write that the full FIFO could not take.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (tx_write_i && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule
